fantasticfft_fft8_seq: RTL and testbench

Frame sequencer for the 8-point FFT core. It collects a serial stream of real input samples into an 8-entry frame and presents the frame in parallel to the core. It waits the core's fixed latency, captures the 8 complex bins, and streams them out one bin per handshake. It sits between the sample source and the result consumer and is the only block that drives the core's `x0..x7` inputs.

---
 rtl/fantasticfft_fft8_seq.sv | 122 ++++++++++++
 tb/tb_fantasticfft_fft8_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fantasticfft_fft8_seq.sv
// Frame sequencer for the 8-point FFT core.
// Serial samples in, parallel frame to the core, serial bins out.
module fantasticfft_fft8_seq #(
    parameter int INPUT_SIZE   = 8,
    parameter int CORE_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INPUT_SIZE-1:0]     in_data,
    output logic [8*INPUT_SIZE-1:0]   core_x,
    input  logic [8*INPUT_SIZE-1:0]   core_y_re,
    input  logic [8*INPUT_SIZE-1:0]   core_y_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INPUT_SIZE-1:0]     out_re,
    output logic [INPUT_SIZE-1:0]     out_im,
    output logic [2:0]                out_index,
    output logic                      out_last,
    output logic [15:0]               frames_done
);

    localparam int W = INPUT_SIZE;

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        DRAIN
    } state_t;

    state_t         state;
    logic [2:0]     wr_cnt;
    logic [2:0]     rd_cnt;
    logic [2:0]     rd_nxt;
    logic [3:0]     wcnt;
    logic [W-1:0]   slot   [8];
    logic [W-1:0]   buf_re [8];
    logic [W-1:0]   buf_im [8];

    assign in_ready = (state == FILL);
    assign rd_nxt   = rd_cnt + 3'd1;

    // Input slots drive the core directly; x0 sits in the LSBs.
    always_comb begin
        core_x = '0;
        for (int k = 0; k < 8; k++) begin
            core_x[k*W +: W] = slot[k];
        end
    end

    // Frame sequencing: fill slots, wait out the core, drain bins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            wcnt        <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_index   <= '0;
            out_re      <= '0;
            out_im      <= '0;
            frames_done <= '0;
            for (int k = 0; k < 8; k++) begin
                slot[k]   <= '0;
                buf_re[k] <= '0;
                buf_im[k] <= '0;
            end
        end else begin
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        slot[wr_cnt] <= in_data;
                        wr_cnt       <= wr_cnt + 3'd1;
                        if (wr_cnt == 3'd7) begin
                            wcnt  <= 4'(CORE_LATENCY);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd0) begin
                        for (int k = 0; k < 8; k++) begin
                            buf_re[k] <= core_y_re[k*W +: W];
                            buf_im[k] <= core_y_im[k*W +: W];
                        end
                        rd_cnt    <= '0;
                        out_valid <= 1'b1;
                        out_re    <= core_y_re[W-1:0];
                        out_im    <= core_y_im[W-1:0];
                        out_index <= '0;
                        out_last  <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_cnt == 3'd7) begin
                            frames_done <= frames_done + 16'd1;
                            rd_cnt      <= '0;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_index   <= '0;
                            state       <= FILL;
                        end else begin
                            rd_cnt    <= rd_nxt;
                            out_re    <= buf_re[rd_nxt];
                            out_im    <= buf_im[rd_nxt];
                            out_index <= rd_nxt;
                            out_last  <= (rd_nxt == 3'd7);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fantasticfft_fft8_seq.sv
// Bench for the FFT frame sequencer with stub cores
// (y_re = x, y_im = ~x) at latencies 1, 0 and 4.
module tb_fantasticfft_fft8_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance, latency 1
    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic [W-1:0]  in_data, out_re, out_im;
    logic [2:0]    out_index;
    logic [15:0]   frames_done;
    logic [8*W-1:0] core_x, y_re, y_im;

    fantasticfft_fft8_seq #(.INPUT_SIZE(W), .CORE_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_x(core_x), .core_y_re(y_re), .core_y_im(y_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_index(out_index),
        .out_last(out_last), .frames_done(frames_done)
    );

    // stub core, one register stage
    always @(posedge clk) begin
        y_re <= core_x;
        y_im <= ~core_x;
    end

    // sweep instances sharing stimulus
    logic           s_valid;
    logic           s_ready = 1'b1;
    logic [W-1:0]   s_data;
    logic           s0_ir, s0_ov, s0_last, s4_ir, s4_ov, s4_last;
    logic [W-1:0]   s0_re, s0_im, s4_re, s4_im;
    logic [2:0]     s0_idx, s4_idx;
    logic [15:0]    s0_fd, s4_fd;
    logic [8*W-1:0] s0_x, s4_x, s0_yre, s0_yim, s4_yre, s4_yim;
    logic [8*W-1:0] p4 [4];

    fantasticfft_fft8_seq #(.INPUT_SIZE(W), .CORE_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s0_ir), .in_data(s_data),
        .core_x(s0_x), .core_y_re(s0_yre), .core_y_im(s0_yim),
        .out_valid(s0_ov), .out_ready(s_ready),
        .out_re(s0_re), .out_im(s0_im), .out_index(s0_idx),
        .out_last(s0_last), .frames_done(s0_fd)
    );

    fantasticfft_fft8_seq #(.INPUT_SIZE(W), .CORE_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s4_ir), .in_data(s_data),
        .core_x(s4_x), .core_y_re(s4_yre), .core_y_im(s4_yim),
        .out_valid(s4_ov), .out_ready(s_ready),
        .out_re(s4_re), .out_im(s4_im), .out_index(s4_idx),
        .out_last(s4_last), .frames_done(s4_fd)
    );

    assign s0_yre = s0_x;
    assign s0_yim = ~s0_x;

    always @(posedge clk) begin
        p4[0] <= s4_x;
        for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
    end
    assign s4_yre = p4[3];
    assign s4_yim = ~p4[3];

    int vectors = 0;
    int miscompares = 0;
    int fd_exp = 0;
    logic [W-1:0] frame [8];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) frame[i] = W'($urandom);
    endtask

    // push frame[] into the main instance; E is the edge taking slot 7
    task automatic send(input bit gaps, input bit hold, output int e);
        int g;
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                g = $urandom_range(2, 0);
                repeat (g) begin
                    in_valid = 1'b0;
                    chk("in_ready_gap", in_ready, 1);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            chk("in_ready_fill", in_ready, 1);
            tick();
        end
        e = cyc;
        in_valid = hold;
    endtask

    // collect the 8 bins and compare with frame[]
    task automatic drain(input int e, input int stall_at, input int stall_len,
                         input bit rnd, input bit hold);
        int n, b, st;
        bit rdy;
        logic [8*W-1:0] px;
        logic [W-1:0] ei;
        n = 0; b = 0; st = 0;
        for (int k = 0; k < 8; k++) px[k*W +: W] = frame[k];
        chk("core_x_frame", (core_x == px), 1);
        out_ready = 1'b1;
        while (!out_valid && b < 20) begin
            chk("in_ready_wait", in_ready, 0);
            if (hold) in_data = W'($urandom);
            tick();
            b++;
        end
        chk("valid_rise", cyc, e + 2);
        while (n < 8 && b < 200) begin
            ei = ~frame[n];
            chk("out_valid", out_valid, 1);
            chk("in_ready_drain", in_ready, 0);
            chk("out_index", out_index, n);
            chk("out_re", out_re, frame[n]);
            chk("out_im", out_im, ei);
            chk("out_last", out_last, (n == 7));
            if (n == stall_at && st < stall_len) begin
                rdy = 1'b0;
                st++;
            end else begin
                rdy = rnd ? 1'($urandom) : 1'b1;
            end
            out_ready = rdy;
            if (hold) in_data = W'($urandom);
            tick();
            b++;
            if (rdy) n++;
        end
        chk("bins_drained", n, 8);
        out_ready = 1'b1;
        fd_exp++;
        chk("in_ready_back", in_ready, 1);
        chk("out_valid_low", out_valid, 0);
        chk("frames_done", frames_done, fd_exp);
    endtask

    initial begin
        int e, e_prev, r0, r4, n0, n4;
        logic [W-1:0] ei;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_valid = 1'b0; s_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_core_x", (core_x == '0), 1);

        // basic frame 1..8
        for (int i = 0; i < 8; i++) frame[i] = W'(i + 1);
        send(0, 0, e);
        drain(e, -1, 0, 0, 0);

        // output backpressure at bin 3
        rand_frame();
        send(0, 0, e);
        drain(e, 3, 5, 0, 0);

        // gapped input, in_valid held through WAIT/DRAIN
        rand_frame();
        send(1, 1, e);
        drain(e, -1, 0, 0, 1);
        rand_frame();
        send(0, 0, e);
        drain(e, -1, 0, 1, 0);

        // reset mid-frame
        rand_frame();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fd_exp = 0;
        chk("mid_rst_frames", frames_done, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_core_x", (core_x == '0), 1);
        for (int i = 0; i < 8; i++) frame[i] = W'(8'h10 + i);
        send(0, 0, e);
        drain(e, -1, 0, 0, 0);

        // back-to-back frames
        e_prev = -1;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send(0, 1, e);
            if (e_prev >= 0) chk("frame_period", e - e_prev, 18);
            e_prev = e;
            drain(e, -1, 0, 0, 1);
        end
        in_valid = 1'b0;

        // latency sweep on the 0 and 4 builds
        rand_frame();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = frame[i];
            chk("lat0_in_ready", s0_ir, 1);
            chk("lat4_in_ready", s4_ir, 1);
            tick();
        end
        e = cyc;
        s_valid = 1'b0;
        r0 = -1; r4 = -1; n0 = 0; n4 = 0;
        for (int t = 0; t < 30 && !(n0 == 8 && n4 == 8); t++) begin
            if (s0_ov) begin
                if (r0 < 0) r0 = cyc;
                if (n0 < 8) begin
                    ei = ~frame[n0];
                    chk("lat0_re", s0_re, frame[n0]);
                    chk("lat0_im", s0_im, ei);
                    chk("lat0_idx", s0_idx, n0);
                    chk("lat0_last", s0_last, (n0 == 7));
                end else chk("lat0_extra_bin", 1, 0);
                n0++;
            end
            if (s4_ov) begin
                if (r4 < 0) r4 = cyc;
                if (n4 < 8) begin
                    ei = ~frame[n4];
                    chk("lat4_re", s4_re, frame[n4]);
                    chk("lat4_im", s4_im, ei);
                    chk("lat4_idx", s4_idx, n4);
                    chk("lat4_last", s4_last, (n4 == 7));
                end else chk("lat4_extra_bin", 1, 0);
                n4++;
            end
            tick();
        end
        chk("lat0_capture", r0, e + 1);
        chk("lat4_capture", r4, e + 5);
        chk("lat0_bins", n0, 8);
        chk("lat4_bins", n4, 8);
        chk("lat0_frames", s0_fd, 1);
        chk("lat4_frames", s4_fd, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
